// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for the data cache line interface. It accepts one
//   request at a time (128-bit line read or 32-bit word write-through) and
//   answers it after a fixed latency of LAT cycles. The answer is handed over
//   with a valid/ready response handshake.
//
// Parameters
//   IDX_W : line index width; storage holds 2^IDX_W lines of 128 bits
//   LAT   : cycles from request acceptance to rsp_valid (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept a request
//   req_we     in   1 = word write, 0 = line read
//   req_addr   in   byte address (bits [IDX_W+3:4] line, [3:2] word)
//   req_wdata  in   write data for word writes
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts the response
//   rsp_we     out  echo of the accepted req_we
//   rsp_data   out  addressed line, including any word just written
module line_mem_responder #(
    parameter int IDX_W = 6,
    parameter int LAT   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_we,
    output logic [127:0] rsp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_we_q, rsp_we_d;
    logic [127:0]     rsp_data_q, rsp_data_d;
    logic             commit;

    logic [127:0]     mem_q [0:(1<<IDX_W)-1];
    logic [127:0]     line_rd;
    logic [127:0]     line_merged;

    // Address bits above the line index alias, and byte offsets are ignored.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:IDX_W+4], req_addr[1:0]};

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   sel,
                                                input logic [31:0]  data);
        logic [127:0] r;
        r = line;
        r[{sel, 5'b0} +: 32] = data;
        return r;
    endfunction

    // Ready is gated by reset directly so it drops the moment reset asserts.
    assign req_ready = (state_q == S_IDLE) && rst;

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_data  = rsp_data_q;

    assign line_rd     = mem_q[idx_q];
    assign line_merged = we_q ? merge_word(line_rd, sel_q, wdata_q) : line_rd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_data_d  = rsp_data_q;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    idx_d   = req_addr[IDX_W+3:4];
                    sel_d   = req_addr[3:2];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Write commit and response capture happen on the same
                    // edge, so the response already shows the new word.
                    commit      = 1'b1;
                    rsp_data_d  = line_merged;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            sel_q       <= 2'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= 128'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage keeps its contents across reset; a reset before the commit
    // edge returns the FSM to IDLE, which discards the pending write.
    always_ff @(posedge clk) begin
        if (commit && we_q) begin
            mem_q[idx_q] <= line_merged;
        end
    end

endmodule
